// File: rtl/gpio_irq_pkg.sv
// Shared constants and helpers for the Wishbone GPIO controller with edge interrupts.
package gpio_irq_pkg;

  // Address-field widths: register index is adr[7:5], bank index is adr[4:2].
  localparam int REG_IDX_W  = 3;
  localparam int BANK_IDX_W = 3;
  localparam int BANK_W     = 32;

  // Largest pad count the 3-bit bank field can address (8 banks x 32 bits).
  localparam int MAX_IO = 256;

  // Register indices within the 0x100-byte window.
  localparam logic [REG_IDX_W-1:0] REG_OUT  = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_OEB  = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_IN   = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_RISE = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_FALL = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_STAT = 3'd5;

  // Number of 32-bit banks needed to hold num_io pads.
  function automatic int nbanks(input int num_io);
    return (num_io + 31) / 32;
  endfunction

  // Expand the four byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Replace only the selected bytes of old_val with new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] m;
    m = byte_mask(sel);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/gpio_irq_sync_edge.sv
// Multi-stage input synchroniser with a history flop; reports raw rising/falling edges.
module gpio_sync_edge #(
  parameter int WIDTH       = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] hist_r;

  // Shift the asynchronous pad values through the synchroniser, then into the history flop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      hist_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign s    = sync_r[SYNC_STAGES-1];
  assign rise = s & ~hist_r;
  assign fall = ~s & hist_r;

endmodule

// File: rtl/user_project_gpio_irq.sv
// Wishbone GPIO controller: per-pad output data, output enable, synchronised
// readback and rising/falling-edge interrupts with write-1-to-clear status.
module user_project_gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h300F_FF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq_o
);

  localparam int         NB   = nbanks(NUM_IO);
  localparam logic [3:0] NB_V = 4'(NB);

  // Architectural registers, only NUM_IO bits wide: unimplemented bits simply do not exist.
  logic [NUM_IO-1:0] out_r, oeb_r, rise_en_r, fall_en_r, stat_r;
  logic              ack_r;
  logic [31:0]       dat_r;

  // Synchroniser outputs.
  logic [NUM_IO-1:0] sync_s, rise_raw_s, fall_raw_s, event_s;

  // Registers zero-padded to the full addressable width so any bank index is a legal slice.
  logic [MAX_IO-1:0] out_pad_s, oeb_pad_s, in_pad_s, rise_pad_s, fall_pad_s, stat_pad_s, event_pad_s;
  logic [MAX_IO-1:0] out_nxt_s, oeb_nxt_s, rise_nxt_s, fall_nxt_s, stat_nxt_s, clr_s;

  logic                  hit_s, req_s, wr_s, bank_ok_s;
  logic [REG_IDX_W-1:0]  reg_idx_s;
  logic [BANK_IDX_W-1:0] bank_s;
  logic [7:0]            bank_base_s;
  logic [31:0]           rd_data_s;
  logic                  unused_s;

  gpio_sync_edge #(
    .WIDTH       (NUM_IO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .din      (io_in),
    .s        (sync_s),
    .rise     (rise_raw_s),
    .fall     (fall_raw_s)
  );

  assign event_s = (rise_raw_s & rise_en_r) | (fall_raw_s & fall_en_r);

  assign hit_s       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign reg_idx_s   = wbs_adr_i[7:5];
  assign bank_s      = wbs_adr_i[4:2];
  assign bank_base_s = {bank_s, 5'b00000};
  assign bank_ok_s   = ({1'b0, bank_s} < NB_V);
  assign req_s       = wbs_cyc_i & wbs_stb_i & hit_s & ~ack_r;
  assign wr_s        = req_s & wbs_we_i;

  // Zero-extend every register to the full bank-addressable width.
  always_comb begin
    out_pad_s   = {MAX_IO{1'b0}};
    oeb_pad_s   = {MAX_IO{1'b0}};
    in_pad_s    = {MAX_IO{1'b0}};
    rise_pad_s  = {MAX_IO{1'b0}};
    fall_pad_s  = {MAX_IO{1'b0}};
    stat_pad_s  = {MAX_IO{1'b0}};
    event_pad_s = {MAX_IO{1'b0}};
    out_pad_s[NUM_IO-1:0]   = out_r;
    oeb_pad_s[NUM_IO-1:0]   = oeb_r;
    in_pad_s[NUM_IO-1:0]    = sync_s;
    rise_pad_s[NUM_IO-1:0]  = rise_en_r;
    fall_pad_s[NUM_IO-1:0]  = fall_en_r;
    stat_pad_s[NUM_IO-1:0]  = stat_r;
    event_pad_s[NUM_IO-1:0] = event_s;
  end

  // Compute next register values from a byte-masked write; IN and reserved slots are read-only.
  always_comb begin
    out_nxt_s  = out_pad_s;
    oeb_nxt_s  = oeb_pad_s;
    rise_nxt_s = rise_pad_s;
    fall_nxt_s = fall_pad_s;
    clr_s      = {MAX_IO{1'b0}};
    if (wr_s && bank_ok_s) begin
      case (reg_idx_s)
        REG_OUT:  out_nxt_s[bank_base_s +: BANK_W]  = merge_bytes(out_pad_s[bank_base_s +: BANK_W], wbs_dat_i, wbs_sel_i);
        REG_OEB:  oeb_nxt_s[bank_base_s +: BANK_W]  = merge_bytes(oeb_pad_s[bank_base_s +: BANK_W], wbs_dat_i, wbs_sel_i);
        REG_RISE: rise_nxt_s[bank_base_s +: BANK_W] = merge_bytes(rise_pad_s[bank_base_s +: BANK_W], wbs_dat_i, wbs_sel_i);
        REG_FALL: fall_nxt_s[bank_base_s +: BANK_W] = merge_bytes(fall_pad_s[bank_base_s +: BANK_W], wbs_dat_i, wbs_sel_i);
        REG_STAT: clr_s[bank_base_s +: BANK_W]      = wbs_dat_i & byte_mask(wbs_sel_i);
        default:  clr_s = {MAX_IO{1'b0}};
      endcase
    end else begin
      clr_s = {MAX_IO{1'b0}};
    end
    // New events are ORed in after the clear so a coincident event keeps the bit set.
    stat_nxt_s = (stat_pad_s & ~clr_s) | event_pad_s;
  end

  // Select the addressed bank of the addressed register; reserved slots and absent banks read 0.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (bank_ok_s) begin
      case (reg_idx_s)
        REG_OUT:  rd_data_s = out_pad_s[bank_base_s +: BANK_W];
        REG_OEB:  rd_data_s = oeb_pad_s[bank_base_s +: BANK_W];
        REG_IN:   rd_data_s = in_pad_s[bank_base_s +: BANK_W];
        REG_RISE: rd_data_s = rise_pad_s[bank_base_s +: BANK_W];
        REG_FALL: rd_data_s = fall_pad_s[bank_base_s +: BANK_W];
        REG_STAT: rd_data_s = stat_pad_s[bank_base_s +: BANK_W];
        default:  rd_data_s = 32'h0000_0000;
      endcase
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Bus handshake: one-cycle ack per request; read data is only non-zero while ack is high.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= req_s;
      dat_r <= req_s ? rd_data_s : 32'h0000_0000;
    end
  end

  // Commit register updates on the same edge that raises ack; status tracks events continuously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_r     <= {NUM_IO{1'b0}};
      oeb_r     <= {NUM_IO{1'b1}};
      rise_en_r <= {NUM_IO{1'b0}};
      fall_en_r <= {NUM_IO{1'b0}};
      stat_r    <= {NUM_IO{1'b0}};
    end else begin
      out_r     <= out_nxt_s[NUM_IO-1:0];
      oeb_r     <= oeb_nxt_s[NUM_IO-1:0];
      rise_en_r <= rise_nxt_s[NUM_IO-1:0];
      fall_en_r <= fall_nxt_s[NUM_IO-1:0];
      stat_r    <= stat_nxt_s[NUM_IO-1:0];
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign io_out    = out_r;
  assign io_oeb    = oeb_r;
  assign irq_o     = |stat_r;

  // Padding bits above NUM_IO and the byte offset in the address carry no information.
  assign unused_s = ^{wbs_adr_i[1:0], out_nxt_s, oeb_nxt_s, rise_nxt_s, fall_nxt_s, stat_nxt_s};

endmodule

// File: doc/user_project_gpio_irq.md
Name: user_project_gpio_irq

Overview:
Parametrised Wishbone GPIO controller for the user project area. It supports NUM_IO pads split into 32-bit banks, with per-pad output data, output-enable (OEB) and synchronised input readback. Each pad also has rising- and falling-edge interrupt detection with write-1-to-clear status, and all sources are ORed onto a single irq_o. It sits on the management Wishbone bus and drives the user io_out/io_oeb pads.

Parameters:
NUM_IO, 38, number of GPIO pads (1..256); banks NB = ceil(NUM_IO/32).
BASE_ADDR, 32'h300F_FF00, register window base; bits [7:0] must be 0.
SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
wb_clk_i  in  1  bus/system clock
wb_rst_i  in  1  reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  NUM_IO  pad inputs (asynchronous)
io_out  out  NUM_IO  pad output data
io_oeb  out  NUM_IO  pad output enable, active-low
irq_o  out  1  level interrupt, OR of all status bits

Behaviour:
- Reset wb_rst_i, asynchronous, active-high; clock wb_clk_i.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - OUT=0, so io_out=0.
  - OEB=all 1s, so io_oeb=all 1s and every pad is an input.
  - RISE=0, FALL=0, STAT=0, irq_o=0.
  - Synchroniser and edge-history flops = 0.
- Decode:
  - Hit when adr[31:8]==BASE_ADDR[31:8].
  - Register index r = adr[7:5]; bank b = adr[4:2]; adr[1:0] ignored.
- Register map (byte address = BASE + r*0x20 + b*4):
  - r0 OUT: RW.
  - r1 OEB: RW.
  - r2 IN: RO, synchronised pad value.
  - r3 RISE: RW, rising-edge enable.
  - r4 FALL: RW, falling-edge enable.
  - r5 STAT: read; writing 1 clears a bit, writing 0 has no effect.
  - r6, r7: reserved.
- Handshake:
  - When cyc&stb&hit&!ack, ack=1 on the next edge for exactly one cycle.
  - Back-to-back strobes therefore get an ack every other cycle.
  - wbs_dat_o is valid only while ack=1 and is 0 otherwise.
  - A non-hit address never acks.
  - Reserved registers, and banks b>=NB, ack with read data 0; writes to them are ignored.
- Writes honour wbs_sel_i per byte.
  - Bits at or above NUM_IO in the top bank are not implemented: they read 0 and writes are ignored.
  - Writes to IN are ignored.
- Input path:
  - io_in passes through SYNC_STAGES flops to give s, then one history flop gives p.
  - IN reads s, so a pad change is readable SYNC_STAGES cycles later.
- Edge detection:
  - rise = s&~p&RISE; fall = ~s&p&FALL.
  - STAT[i] sets on rise|fall, one cycle after s changes (SYNC_STAGES+1 cycles from pad change).
  - STAT stays set until cleared by W1C.
- Simultaneous W1C and new event on the same bit in the same cycle: the set wins and the bit stays 1.
- Clearing RISE/FALL does not clear STAT.
- irq_o = |STAT (OR of flops, no extra latency).
- Outputs: io_out=OUT[NUM_IO-1:0]; io_oeb=OEB[NUM_IO-1:0]. Register writes reach the pads on the same edge as ack.
- Reset mid-transaction:
  - ack drops immediately and no write is committed.
  - The master must re-issue the access after reset.

Decomposition:
- Package gpio_irq_pkg:
  - Register index constants REG_OUT..REG_STAT.
  - Function nbanks(NUM_IO).
  - Width constants for the address-field slices [7:5] and [4:2].
- Sub-module gpio_sync_edge: per-bank vector synchroniser plus history flop. Outputs s, rise and fall. Parametrised by width and SYNC_STAGES. Instantiated once with width NUM_IO.
- Top level holds the Wishbone FSM (IDLE/ACK, expressed via the ack flop), register banks and the read mux.

Test Plan:
- Reset with NUM_IO=38 -> io_oeb=38'h3F_FFFF_FFFF, io_out=0, irq_o=0; read 0x300FFF20 returns 0xFFFFFFFF and 0x300FFF24 returns 0x0000003F.
- Write 0xA5A5A5A5 to 0x300FFF00 with sel=4'b0101, then write 0xFFFFFFFF to 0x300FFF04 -> io_out[31:0]=0x00A500A5 and io_out[37:32]=6'h3F; reading 0x300FFF04 returns 0x0000003F; ack high exactly 1 cycle per access.
- Write 0x10 to RISE 0x300FFF60, then drive io_in[4] 0->1 -> IN 0x300FFF40 bit4=1 after 2 cycles; STAT 0x300FFFA0 = 0x10 and irq_o=1 after 3 cycles; write 0x10 to 0x300FFFA0 -> STAT=0, irq_o=0.
- Set FALL bit 33 (0x300FFF84 = 0x2); align a falling edge on io_in[33] with a W1C of 0x2 to 0x300FFFA4 -> STAT bit stays 1, irq_o stays 1.
- Read reserved 0x300FFFC0 and bank 2 at 0x300FFF08 -> ack asserted, data 0; write 0xFFFFFFFF to 0x300FFF08 -> no output changes. Address 0x300FFE00 -> no ack for 8 cycles.
- Assert wb_rst_i in the cycle after a write strobe, before ack -> ack=0, OUT is unchanged at 0, all outputs return to reset values asynchronously.
